pc_fetch_unit: RTL and testbench

- Program-counter register and fetch sequencer for the single-cycle core.
- Drives the current PC into the sequential PC adder and into instruction memory.
- Takes back the adder's PC+4 result and selects the next PC from that result or a branch/jump redirect.
- Holds the PC under stall or memory wait, and traps on misaligned targets.

---
 rtl/pc_fetch_unit_pkg.sv | 14 +
 rtl/pc_next_sel.sv | 17 +
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared widths, reset PC, step size and fetch FSM encoding.
package pc_fetch_unit_pkg;
  localparam int REGISTER_WIDTH = 32;
  localparam logic [REGISTER_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_e;
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (redirect > pending > sequential) with word-alignment check.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int W = REGISTER_WIDTH
) (
  input  logic         redirect_valid,
  input  logic [W-1:0] redirect_target,
  input  logic         pend_valid,
  input  logic [W-1:0] pend_target,
  input  logic [W-1:0] seq_pc,
  output logic [W-1:0] next_pc,
  output logic         misaligned
);
  assign next_pc    = redirect_valid ? redirect_target : pend_valid ? pend_target : seq_pc;
  assign misaligned = word_misaligned(next_pc[1:0]);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch sequencer with pending redirects and misalign trap.
module pc_fetch_unit #(
  parameter int REGISTER_WIDTH = pc_fetch_unit_pkg::REGISTER_WIDTH,
  parameter logic [REGISTER_WIDTH-1:0] RESET_PC = pc_fetch_unit_pkg::RESET_PC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REGISTER_WIDTH-1:0] seq_pc,
  input  logic                      redirect_valid,
  input  logic [REGISTER_WIDTH-1:0] redirect_target,
  input  logic                      stall,
  input  logic                      imem_ready,
  input  logic                      trap_clear,
  output logic [REGISTER_WIDTH-1:0] pc,
  output logic                      imem_req,
  output logic                      fetch_done,
  output logic                      misalign_trap,
  output logic [REGISTER_WIDTH-1:0] trap_pc,
  output logic [REGISTER_WIDTH-1:0] fetch_count
);
  import pc_fetch_unit_pkg::*;
  fetch_state_e state_q, state_d;
  logic [REGISTER_WIDTH-1:0] pc_q, pc_d;
  logic [REGISTER_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [REGISTER_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic [REGISTER_WIDTH-1:0] fetch_count_q, fetch_count_d;
  logic pend_valid_q, pend_valid_d;
  logic trap_q, trap_d;
  logic [REGISTER_WIDTH-1:0] next_pc;
  logic next_misaligned;
  pc_next_sel #(.W(REGISTER_WIDTH)) u_next_sel (
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pend_valid      (pend_valid_q),
    .pend_target     (pend_target_q),
    .seq_pc          (seq_pc),
    .next_pc         (next_pc),
    .misaligned      (next_misaligned)
  );
  assign imem_req   = (state_q == RUN) && !stall;
  assign fetch_done = imem_req && imem_ready;
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    trap_pc_d     = trap_pc_q;
    trap_d        = trap_q;
    fetch_count_d = fetch_count_q;
    if (state_q == BOOT) state_d = RUN;
    if (state_q == RUN) begin
      if (fetch_done) begin
        fetch_count_d = fetch_count_q + REGISTER_WIDTH'(1);
        pend_valid_d  = 1'b0;
        if (next_misaligned) begin
          trap_pc_d = next_pc;
          trap_d    = 1'b1;
          state_d   = TRAP;
        end else begin
          pc_d = next_pc;
        end
      end else if (redirect_valid) begin
        // Redirect arrived while the fetch is held; replay it on the next accepted fetch.
        pend_valid_d  = 1'b1;
        pend_target_d = redirect_target;
      end
    end
    if (state_q == TRAP && trap_clear) begin
      pc_d         = RESET_PC;
      pend_valid_d = 1'b0;
      trap_d       = 1'b0;
      state_d      = BOOT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      trap_pc_q     <= '0;
      trap_q        <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      trap_pc_q     <= trap_pc_d;
      trap_q        <= trap_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign pc            = pc_q;
  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;
  assign fetch_count   = fetch_count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch traffic checked by a scoreboard against a reference model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;
  localparam int W = 32;
  localparam logic [W-1:0] RST_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] seq_pc;
  logic redirect_valid = 1'b0;
  logic [W-1:0] redirect_target = '0;
  logic stall = 1'b0;
  logic imem_ready = 1'b0;
  logic trap_clear = 1'b0;
  logic [W-1:0] pc, trap_pc, fetch_count;
  logic imem_req, fetch_done, misalign_trap;
  always #5 clk = ~clk;
  assign seq_pc = pc + W'(PC_STEP);
  pc_fetch_unit #(.REGISTER_WIDTH(W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .seq_pc(seq_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall(stall), .imem_ready(imem_ready), .trap_clear(trap_clear),
    .pc(pc), .imem_req(imem_req), .fetch_done(fetch_done),
    .misalign_trap(misalign_trap), .trap_pc(trap_pc), .fetch_count(fetch_count)
  );
  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] cnt;
  } fetch_t;
  fetch_t fq[$];
  logic [W-1:0] tq[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference model: a fetch is either booting, running or trapped; one optional pending redirect.
  logic [W-1:0] m_pc, m_cnt, m_pend_t;
  bit m_pend, m_boot, m_trap;
  task automatic model_reset();
    m_pc = RST_PC; m_cnt = '0; m_pend = 0; m_pend_t = '0; m_boot = 1; m_trap = 0;
  endtask
  task automatic model_step();
    bit running, fetch;
    logic [W-1:0] tgt;
    running = !m_boot && !m_trap;
    fetch = running && !stall && imem_ready;
    if (fetch) begin
      fq.push_back('{pc: m_pc, cnt: m_cnt});
      tgt = redirect_valid ? redirect_target : (m_pend ? m_pend_t : m_pc + W'(PC_STEP));
      m_cnt = m_cnt + 1;
      m_pend = 0;
      if (tgt[1:0] != 2'b00) begin
        m_trap = 1;
        tq.push_back(tgt);
      end else m_pc = tgt;
    end else if (running && redirect_valid) begin
      m_pend = 1;
      m_pend_t = redirect_target;
    end else if (m_trap && trap_clear) begin
      m_trap = 0; m_pend = 0; m_pc = RST_PC; m_boot = 1;
    end else if (m_boot) m_boot = 0;
  endtask
  logic prev_trap = 1'b0;
  fetch_t e;
  logic [W-1:0] et;
  always @(negedge clk) begin
    if (!rst_n) prev_trap = 1'b0;
    else begin
      if (fetch_done) begin
        if (fq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_fetch: got fetch at pc %h expected none", pc);
        end else begin
          e = fq.pop_front();
          check("fetch_pc", pc, e.pc);
          check("fetch_count", fetch_count, e.cnt);
        end
      end
      if (misalign_trap && !prev_trap) begin
        if (tq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_trap: got trap_pc %h expected no trap", trap_pc);
        end else begin
          et = tq.pop_front();
          check("trap_pc", trap_pc, et);
        end
      end
      prev_trap = misalign_trap;
    end
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, RST_PC);
    check("reset_req", {31'b0, imem_req}, '0);
    check("reset_count", fetch_count, '0);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (cyc > 30 && $urandom % 200 == 0 && tq.size() == 0) begin
        imem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, RST_PC);
        check("async_rst_req", {31'b0, imem_req}, '0);
        check("async_rst_done", {31'b0, fetch_done}, '0);
        check("async_rst_trap", {31'b0, misalign_trap}, '0);
        check("async_rst_trap_pc", trap_pc, '0);
        check("async_rst_count", fetch_count, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("boot_idle_req", {31'b0, imem_req}, '0);
      end
      if (cyc < 20) begin
        stall = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0; trap_clear = 1'b0;
      end else begin
        stall = ($urandom % 4 == 0);
        imem_ready = ($urandom % 4 != 0);
        redirect_valid = ($urandom % 5 == 0);
        redirect_target = W'($urandom_range(0, 255)) << 2;
        if ($urandom % 8 == 0) redirect_target[1:0] = 2'($urandom_range(1, 3));
        trap_clear = m_trap ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      end
      model_step();
    end
    @(posedge clk);
    #1;
    stall = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0; trap_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fetch_queue_drained", W'(fq.size()), '0);
    check("trap_queue_drained", W'(tq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
